// File: rtl/mem_fill_responder.sv
// Fill-path memory: 16-bit word array with a LATENCY-deep read pipe. `MEM_FILL_BURST_EN enables 8-beat critical-word-first fills.
// Reads return LATENCY cycles after acceptance; writes never stall; req_ready drops only during burst beats 1..7.
module mem_fill_responder #(
  parameter int LATENCY        = 4,
  parameter int MEM_WORDS_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_burst,
  input  logic [15:0] req_addr,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        req_ready,
  output logic        data_valid,
  output logic [15:0] data_out,
  output logic [15:0] resp_addr
);

  localparam int DEPTH = 1 << MEM_WORDS_LOG2;

  typedef struct packed {
    logic        vld;
    logic [15:0] addr;
    logic [15:0] dat;
  } stage_t;

  logic [15:0]               mem [DEPTH];
  logic                      rd_vld;
  logic [15:0]               rd_addr;
  logic [MEM_WORDS_LOG2-1:0] rd_idx;
  logic [MEM_WORDS_LOG2-1:0] wr_idx;
  logic [15:0]               rd_dat;
  stage_t                    pipe [LATENCY];

  assign rd_idx = rd_addr[MEM_WORDS_LOG2:1];
  assign wr_idx = wr_addr[MEM_WORDS_LOG2:1];

  // A write landing on the same edge as the read must be seen by that read.
  assign rd_dat = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{vld: rd_vld, addr: {rd_addr[15:1], 1'b0}, dat: rd_dat};
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign data_valid = pipe[LATENCY-1].vld;
  assign data_out   = pipe[LATENCY-1].dat;
  assign resp_addr  = pipe[LATENCY-1].addr;

`ifdef MEM_FILL_BURST_EN
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  beat, beat_nxt;
  logic [11:0] blk, blk_nxt;
  logic [2:0]  first, first_nxt;
  logic [2:0]  beat_off;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      beat  <= 3'd0;
      blk   <= 12'd0;
      first <= 3'd0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      blk   <= blk_nxt;
      first <= first_nxt;
    end
  end

  // Offset wraps inside the 8-word block so the requested word goes first.
  assign beat_off = first + beat;

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    blk_nxt   = blk;
    first_nxt = first;
    req_ready = 1'b1;
    rd_vld    = 1'b0;
    rd_addr   = req_addr;
    case (state)
      IDLE: begin
        rd_vld = req_valid;
        if (req_valid && req_burst) begin
          state_nxt = BURST;
          beat_nxt  = 3'd1;
          blk_nxt   = req_addr[15:4];
          first_nxt = req_addr[3:1];
        end
      end
      BURST: begin
        req_ready = 1'b0;
        rd_vld    = 1'b1;
        rd_addr   = {blk, beat_off, 1'b0};
        beat_nxt  = beat + 3'd1;
        if (beat == 3'd7) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
`else
  assign req_ready = 1'b1;
  assign rd_vld    = req_valid;
  assign rd_addr   = req_addr;
`endif

  logic unused_ok;
  assign unused_ok = ^{req_burst, req_addr[0], rd_addr[0], wr_addr};

endmodule
